// File: rtl/spi_slave_adc_responder.sv
// SPI mode-0 slave that emulates the ADC end of the SPI link; SCK/CSbar/MOSI are oversampled on SYS_CLK.
// Optional feature macro SPI_SLAVE_LEAD_ZERO_EN: send a leading zero, then TX_DATA[MSB:1].
module spi_slave_adc_responder #(
  parameter int DATA_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 SYS_CLK,
  input  logic                 RSTbar,
  input  logic                 SCK,
  input  logic                 CSbar,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 MISO_OE,
  input  logic [DATA_BITS-1:0] TX_DATA,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 RX_VALID,
  output logic                 FRAME_ERR,
  output logic                 BUSY
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sck_d_r;
  logic                   cs_d_r;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise_s, sck_fall_s, cs_rise_s, cs_fall_s;

  state_t state_r, next_state_s;

  logic [DATA_BITS-1:0] tx_shift_r, tx_shift_nxt_s;
  logic [DATA_BITS-2:0] rx_shift_r, rx_shift_nxt_s;
  logic [DATA_BITS-1:0] rx_word_s;
  logic [DATA_BITS-1:0] rx_data_r, rx_data_nxt_s;
  logic [CNT_W-1:0]     bit_cnt_r, bit_cnt_nxt_s;
  logic                 miso_r, miso_nxt_s;
  logic                 oe_r, oe_nxt_s;
  logic                 rx_valid_r, rx_valid_nxt_s;
  logic                 frame_err_r, frame_err_nxt_s;
  logic                 busy_r;
  logic                 first_bit_s;
  logic                 next_bit_s;

  // Synchronisers plus one edge-detect stage; reset loads the bus idle levels.
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      sck_sync_r  <= '0;
      cs_sync_r   <= '1;
      mosi_sync_r <= '0;
      sck_d_r     <= 1'b0;
      cs_d_r      <= 1'b1;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], SCK};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], CSbar};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
      sck_d_r     <= sck_sync_r[SYNC_STAGES-1];
      cs_d_r      <= cs_sync_r[SYNC_STAGES-1];
    end
  end

  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign cs_s       = cs_sync_r[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
  assign sck_rise_s = sck_s & ~sck_d_r;
  assign sck_fall_s = ~sck_s & sck_d_r;
  assign cs_rise_s  = cs_s & ~cs_d_r;
  assign cs_fall_s  = ~cs_s & cs_d_r;
  assign rx_word_s  = {rx_shift_r, mosi_s};

`ifdef SPI_SLAVE_LEAD_ZERO_EN
  // The leading zero occupies the first bit period, so the MSB goes out on the first fall.
  assign first_bit_s = 1'b0;
  assign next_bit_s  = tx_shift_r[DATA_BITS-1];
`else
  assign first_bit_s = TX_DATA[DATA_BITS-1];
  assign next_bit_s  = tx_shift_r[DATA_BITS-2];
`endif

  // State register.
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a CSbar rise always outranks any SCK edge seen in the same cycle.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          next_state_s = ST_ACTIVE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise_s) begin
          next_state_s = ST_IDLE;
        end else if (sck_rise_s && (bit_cnt_r == LAST_BIT)) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_ACTIVE;
        end
      end
      ST_DONE: begin
        if (cs_rise_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_DONE;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output and datapath next values for each state.
  always_comb begin
    miso_nxt_s      = miso_r;
    oe_nxt_s        = oe_r;
    tx_shift_nxt_s  = tx_shift_r;
    rx_shift_nxt_s  = rx_shift_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    rx_data_nxt_s   = rx_data_r;
    rx_valid_nxt_s  = 1'b0;
    frame_err_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          tx_shift_nxt_s = TX_DATA;
          miso_nxt_s     = first_bit_s;
          oe_nxt_s       = 1'b1;
          bit_cnt_nxt_s  = '0;
        end else begin
          miso_nxt_s = 1'b0;
          oe_nxt_s   = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (cs_rise_s) begin
          miso_nxt_s      = 1'b0;
          oe_nxt_s        = 1'b0;
          frame_err_nxt_s = (bit_cnt_r != '0);
        end else if (sck_rise_s) begin
          rx_shift_nxt_s = rx_word_s[DATA_BITS-2:0];
          bit_cnt_nxt_s  = bit_cnt_r + CNT_ONE;
          if (bit_cnt_r == LAST_BIT) begin
            rx_data_nxt_s  = rx_word_s;
            rx_valid_nxt_s = 1'b1;
            miso_nxt_s     = 1'b0;
          end else begin
            rx_data_nxt_s = rx_data_r;
          end
        end else if (sck_fall_s) begin
          tx_shift_nxt_s = tx_shift_r << 1;
          miso_nxt_s     = next_bit_s;
        end else begin
          tx_shift_nxt_s = tx_shift_r;
        end
      end
      ST_DONE: begin
        miso_nxt_s = 1'b0;
        if (cs_rise_s) begin
          oe_nxt_s = 1'b0;
        end else begin
          oe_nxt_s = 1'b1;
        end
      end
      default: begin
        miso_nxt_s = 1'b0;
        oe_nxt_s   = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge SYS_CLK or negedge RSTbar) begin
    if (!RSTbar) begin
      miso_r      <= 1'b0;
      oe_r        <= 1'b0;
      tx_shift_r  <= '0;
      rx_shift_r  <= '0;
      bit_cnt_r   <= '0;
      rx_data_r   <= '0;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      miso_r      <= miso_nxt_s;
      oe_r        <= oe_nxt_s;
      tx_shift_r  <= tx_shift_nxt_s;
      rx_shift_r  <= rx_shift_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      rx_data_r   <= rx_data_nxt_s;
      rx_valid_r  <= rx_valid_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      busy_r      <= (next_state_s != ST_IDLE);
    end
  end

  assign MISO      = miso_r;
  assign MISO_OE   = oe_r;
  assign RX_DATA   = rx_data_r;
  assign RX_VALID  = rx_valid_r;
  assign FRAME_ERR = frame_err_r;
  assign BUSY      = busy_r;

endmodule
